// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Shared state encoding and the default width for the pdivider divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int DIV_WIDTH_DEF = 32;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// One restoring shift-subtract iteration: retires one quotient bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] partial;
   logic [WIDTH:0] diff;

   // partial < 2*dvsr always, so bit WIDTH of the difference is a reliable borrow
   assign partial = {rem_in, quo_in[WIDTH-1]};
   assign diff    = partial - {1'b0, dvsr};
   assign rem_out = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/pdivider.sv
// ============================================================================
// Module : pdivider
// Iterative signed/unsigned divider, one quotient bit per cycle.
// Optional macro PDIVIDER_DIV0_FAST_EN: divide-by-zero skips the CALC phase.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pdivider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             div_clk,
   input  logic             resetn,
   input  logic             div,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             div_zero,
   output logic             ready,
   output logic             complete
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t       state;
   div_state_t       state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] x_abs;
   logic [WIDTH-1:0] y_abs;
   logic             q_neg;
   logic             r_neg;
   logic             dz_pend;
   logic             zero_op;
   logic             accept;
   logic             last_iter;

   assign ready     = (state == IDLE) || (state == DONE);
   assign complete  = (state == DONE);
   assign accept    = div && ready;
   assign zero_op   = (y == '0);
   assign last_iter = (cnt == CW'(WIDTH - 1));
   assign x_abs     = (div_signed && x[WIDTH-1]) ? -x : x;
   assign y_abs     = (div_signed && y[WIDTH-1]) ? -y : y;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .dvsr    (dvsr),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   always_ff @(posedge div_clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
`ifdef PDIVIDER_DIV0_FAST_EN
               state_nxt = zero_op ? FIX : CALC;
`else
               state_nxt = CALC;
`endif
            end else if (state == DONE) begin
               state_nxt = IDLE;
            end
         end
         CALC:    if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge div_clk) begin
      if (!resetn) begin
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         dz_pend  <= 1'b0;
         s        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  cnt     <= '0;
                  dvsr    <= y_abs;
                  q_neg   <= div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
                  r_neg   <= div_signed && x[WIDTH-1];
                  dz_pend <= zero_op;
`ifdef PDIVIDER_DIV0_FAST_EN
                  // With CALC skipped, preload what the iterations would have left behind
                  if (zero_op) begin
                     rem <= x_abs;
                     quo <= '1;
                  end else begin
                     rem <= '0;
                     quo <= x_abs;
                  end
`else
                  rem <= '0;
                  quo <= x_abs;
`endif
               end
            end
            CALC: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               // Re-negating |x| restores x exactly, so r==x also holds for y==0
               s        <= dz_pend ? '1 : (q_neg ? -quo : quo);
               r        <= r_neg ? -rem : rem;
               div_zero <= dz_pend;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
